// File: rtl/system_nios2_qsys_0_mul_seq_pkg.sv
// Shared encodings and widths for the iterative 32x32 multiply sequencer.
// Also holds the partial-product alignment helper used by the accumulator.
package system_nios2_qsys_0_mul_seq_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  typedef enum logic [1:0] {
    MUL_OP_LO  = 2'd0,
    MUL_OP_XUU = 2'd1,
    MUL_OP_XSU = 2'd2,
    MUL_OP_XSS = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DRAIN,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SH_0,
    SH_16,
    SH_32
  } shift_e;

  function automatic logic [ACC_W-1:0] align_pp(input logic [WORD_W-1:0] p, input shift_e sh);
    case (sh)
      SH_0:    return {32'd0, p};
      SH_16:   return {16'd0, p, 16'd0};
      SH_32:   return {p, 32'd0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/system_nios2_qsys_0_mul_seq_cell16.sv
// 16x16 unsigned multiplier with a registered product (one cycle latency).
// Kept as a bare multiply-then-register so it maps onto a hard DSP block.
module system_nios2_qsys_0_mul_seq_cell16
  import system_nios2_qsys_0_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [WORD_W-1:0] p
);

  logic [WORD_W-1:0] p_d, p_q;

  always_comb begin
    p_d = {16'd0, a} * {16'd0, b};
  end

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p_q <= '0;
    else          p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/system_nios2_qsys_0_mul_seq.sv
// Multiply sequencer: issues four 16x16 partial products to one registered cell,
// accumulates them into a 64-bit product, then applies signed high-word fixups.
module system_nios2_qsys_0_mul_seq
  import system_nios2_qsys_0_mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [WORD_W-1:0] req_src1,
  input  logic [WORD_W-1:0] req_src2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data
);

  state_e            state_d, state_q;
  logic [1:0]        k_d, k_q;
  logic [WORD_W-1:0] a_d, a_q, b_d, b_q;
  mul_op_e           op_d, op_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic              tag_valid_d, tag_valid_q;
  shift_e            tag_shift_d, tag_shift_q;
  logic              res_valid_d, res_valid_q;
  logic [WORD_W-1:0] res_data_d, res_data_q;
  logic [HALF_W-1:0] cell_a, cell_b;
  logic [WORD_W-1:0] cell_p;
  logic [WORD_W-1:0] hi_fix;

  system_nios2_qsys_0_mul_seq_cell16 u_cell (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (cell_a),
    .b       (cell_b),
    .p       (cell_p)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    tag_valid_d = 1'b0;
    tag_shift_d = SH_0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    cell_a      = '0;
    cell_b      = '0;
    hi_fix      = acc_q[63:32];

    // The tag travels alongside the cell register, describing the product it holds.
    if (tag_valid_q) acc_d = acc_q + align_pp(cell_p, tag_shift_q);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_src1;
          b_d     = req_src2;
          op_d    = mul_op_e'(req_op);
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        tag_valid_d = 1'b1;
        case (k_q)
          2'd0: begin cell_a = a_q[15:0];  cell_b = b_q[15:0];  tag_shift_d = SH_0;  end
          2'd1: begin cell_a = a_q[31:16]; cell_b = b_q[15:0];  tag_shift_d = SH_16; end
          2'd2: begin cell_a = a_q[15:0];  cell_b = b_q[31:16]; tag_shift_d = SH_16; end
          default: begin cell_a = a_q[31:16]; cell_b = b_q[31:16]; tag_shift_d = SH_32; end
        endcase
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_FIX;
      ST_FIX: begin
        // Signed high word = unsigned high word minus the sign-extension terms.
        if ((op_q == MUL_OP_XSU || op_q == MUL_OP_XSS) && a_q[31]) hi_fix = hi_fix - b_q;
        if (op_q == MUL_OP_XSS && b_q[31])                         hi_fix = hi_fix - a_q;
        res_data_d  = (op_q == MUL_OP_LO) ? acc_q[31:0] : hi_fix;
        res_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= MUL_OP_LO;
      acc_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_shift_q <= SH_0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      tag_valid_q <= tag_valid_d;
      tag_shift_q <= tag_shift_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
